regfile_dump: RTL and testbench
===============================

// Module: regfile_dump
// PURPOSE
//   Sequential reader for the 32x32 register file. It drives one regfile read
//   port and walks an address range, from i_first to i_last inclusive with
//   wrap-around. Each word is streamed out on a valid/ready interface, tagged
//   with its register address. Used for debug/state dump to a host or UART
//   bridge, and as the read-side checker in regfile benches.
// PARAMETERS
//   DATA_W  32  regfile word width
//   ADDR_W  5   regfile address width (depth = 2**ADDR_W)
// PORTS
//   i_clk    in   1       clock; all state updates on posedge
//   i_rst_n  in   1       asynchronous, active-low reset
//   i_start  in   1       start request; sampled only in IDLE
//   i_first  in   ADDR_W  first address; latched with i_start
//   i_last   in   ADDR_W  last address (inclusive); latched with i_start
//   o_raddr  out  ADDR_W  to regfile read address (registered)
//   i_rdata  in   DATA_W  from regfile read data (1-cycle synchronous read)
//   o_data   out  DATA_W  streamed word
//   o_addr   out  ADDR_W  register address of o_data
//   o_valid  out  1       o_data/o_addr/o_last valid
//   i_ready  in   1       consumer accepts when o_valid & i_ready at posedge
//   o_last   out  1       high with the final word of the range
//   o_busy   out  1       high from the cycle after start until DONE exits
//   o_done   out  1       one-cycle pulse after the final handshake
// BEHAVIOUR
//   - Reset (async, any state): state=IDLE; o_raddr, o_data, o_addr = 0;
//     o_valid, o_last, o_busy, o_done = 0. Reset mid-dump aborts the dump.
//     o_valid drops immediately with no handshake. Nothing resumes.
//   - Internal registers: addr (drives o_raddr directly) and end_addr.
//   - FSM states: IDLE, ADDR, READ, SEND, DONE.
//     IDLE: if i_start, latch addr<=i_first and end_addr<=i_last, then go to
//           ADDR. Otherwise stay in IDLE. o_raddr holds its last value.
//     ADDR: o_raddr stable; the regfile samples it at this edge. Go to READ.
//     READ: i_rdata is valid. At the edge: o_data<=i_rdata, o_addr<=addr,
//           o_last<=(addr==end_addr), o_valid<=1. Go to SEND.
//     SEND: hold o_data/o_addr/o_last/o_valid/o_raddr stable while !i_ready.
//           On the handshake, o_valid<=0 and o_last<=0:
//           - if o_last was 1, go to DONE;
//           - else addr<=addr+1 (mod 2**ADDR_W: 31->0) and go to ADDR.
//     DONE: o_done=1 for exactly this cycle. Go to IDLE.
//   - o_busy = 1 in ADDR, READ, SEND and DONE.
//   - i_start outside IDLE is ignored; it is not queued.
//   - Range: word count = ((i_last - i_first) mod 2**ADDR_W) + 1.
//     first>last wraps through 31->0. first==last gives exactly one word.
//   - Latency: start sampled at edge E0. o_valid is high after E2.
//     With i_ready held high, each word takes 3 cycles.
//     A full 0..31 dump spans 96 cycles from E0 to the final handshake.
//   - Read/write coherence: the word reflects the regfile contents at the
//     ADDR->READ edge. A write to the same address at that edge returns the
//     OLD value. Register 0 always reads 0.
//   - o_data/o_addr retain the last word after o_valid falls. They are not
//     cleared except by reset.
// TESTING
//   1. Preload MEM[k]=0xA500_0000|k for k=1..31. Start first=0, last=31, ready=1
//      -> 32 words in order, addr 0..31, data 0 then 0xA500_0001..0xA500_001F.
//      o_last only on addr 31; o_done one cycle after the last handshake;
//      first o_valid 2 edges after start.
//   2. first=30, last=1 -> 4 words with addr 30,31,0,1; o_last on addr 1.
//   3. first=last=7 -> exactly one word (addr 7, 0xA500_0007, o_last=1),
//      then o_done.
//   4. Hold i_ready=0 for 5 cycles while word addr 3 is valid
//      -> o_valid/o_data/o_addr/o_raddr unchanged. Releasing ready gives one
//      handshake, with no duplicated or skipped address.
//   5. Pulse i_start mid-dump -> ignored. Assert i_rst_n=0 during SEND
//      -> o_valid, o_busy, o_last = 0 without waiting for a clock edge.
//      A new start after reset dumps the full new range.
//   6. Write 0xDEAD_BEEF to reg 5 at the same edge its ADDR->READ sample
//      occurs -> the streamed word is the old value 0xA500_0005.
//      A re-dump returns 0xDEAD_BEEF.

Source files
------------

// File: rtl/regfile_dump_if.sv
// Stream bundle carrying one dumped register word and its address.
// Latency: none, wires only.
// Backpressure: the consumer holds i_ready low to stall the producer.
interface regfile_dump_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [DATA_W-1:0] o_data;
  logic [ADDR_W-1:0] o_addr;
  logic              o_valid;
  logic              o_last;
  logic              i_ready;

  // Producer side: the dump engine.
  modport master (
    output o_data,
    output o_addr,
    output o_valid,
    output o_last,
    input  i_ready
  );

  // Consumer side: host bridge, UART, or a bench monitor.
  modport slave (
    input  o_data,
    input  o_addr,
    input  o_valid,
    input  o_last,
    output i_ready
  );
endinterface

// File: rtl/regfile_dump.sv
// Walks a register-file address range (wrapping) and streams each word with its address.
// Latency: first word valid two edges after start; three cycles per word when never stalled.
// Backpressure: o_valid and its payload hold, and the read address freezes, until i_ready.
module regfile_dump #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_first,
  input  logic [ADDR_W-1:0] i_last,
  output logic [ADDR_W-1:0] o_raddr,
  input  logic [DATA_W-1:0] i_rdata,
  output logic              o_busy,
  output logic              o_done,
  regfile_dump_if.master    strm
);

  // IDLE waits for start, ADDR presents the read address, READ captures the
  // synchronous read result, SEND waits for the handshake, DONE pulses once.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_READ = 3'd2,
    S_SEND = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            state_q, state_d;
  // Current read address; drives the regfile directly so it stays stable
  // through ADDR, READ and SEND.
  logic [ADDR_W-1:0] addr_q, addr_d;
  // Inclusive end of the range, latched at start.
  logic [ADDR_W-1:0] end_addr_q, end_addr_d;
  // Output word, its address and last flag; they keep the previous word
  // after o_valid falls.
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] oaddr_q, oaddr_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;

  // Next-state and datapath update, one case arm per state.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    end_addr_d = end_addr_q;
    data_d     = data_q;
    oaddr_d    = oaddr_q;
    valid_d    = valid_q;
    last_d     = last_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          addr_d     = i_first;
          end_addr_d = i_last;
          state_d    = S_ADDR;
        end
      end

      S_ADDR: begin
        // The regfile samples addr_q at the edge that leaves this state.
        state_d = S_READ;
      end

      S_READ: begin
        data_d  = i_rdata;
        oaddr_d = addr_q;
        last_d  = (addr_q == end_addr_q);
        valid_d = 1'b1;
        state_d = S_SEND;
      end

      S_SEND: begin
        if (strm.i_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (last_q) begin
            state_d = S_DONE;
          end else begin
            // Natural wrap at 2**ADDR_W handles ranges with first > last.
            addr_d  = addr_q + 1'b1;
            state_d = S_ADDR;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any dump in progress.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      end_addr_q <= '0;
      data_q     <= '0;
      oaddr_q    <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      end_addr_q <= end_addr_d;
      data_q     <= data_d;
      oaddr_q    <= oaddr_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
    end
  end

  // Status outputs decode straight from the state flop so reset clears them
  // without waiting for an edge.
  always_comb begin
    o_busy = (state_q != S_IDLE);
    o_done = (state_q == S_DONE);
  end

  assign o_raddr      = addr_q;
  assign strm.o_data  = data_q;
  assign strm.o_addr  = oaddr_q;
  assign strm.o_valid = valid_q;
  assign strm.o_last  = last_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: a behavioural regfile, a scoreboard of expected words and a stream monitor.
// Latency: expected words are queued at start; the monitor checks each handshake as it happens.
// Backpressure: i_ready is driven held, stalled or random by the stimulus process.
`timescale 1ns/1ps
module tb_regfile_dump;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 32;

  logic          i_clk;
  logic          i_rst_n;
  logic          i_start;
  logic [AW-1:0] i_first;
  logic [AW-1:0] i_last;
  logic [AW-1:0] o_raddr;
  logic [DW-1:0] i_rdata;
  logic          o_busy;
  logic          o_done;

  regfile_dump_if #(.DATA_W(DW), .ADDR_W(AW)) dif ();

  regfile_dump #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (i_start),
    .i_first (i_first),
    .i_last  (i_last),
    .o_raddr (o_raddr),
    .i_rdata (i_rdata),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .strm    (dif)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Regfile environment: synchronous read, register 0 hardwired to zero,
  // a write at the read edge leaves the read returning the old word.
  logic [DW-1:0] mem [DEPTH];
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  always @(posedge i_clk) begin
    if (rf_we && rf_waddr != '0) mem[rf_waddr] <= rf_wdata;
    i_rdata <= (o_raddr == '0) ? '0 : mem[o_raddr];
  end

  // Reference contents as the bench believes them to be.
  logic [DW-1:0] ref_mem [DEPTH];

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          l;
  } exp_t;
  exp_t sb [$];

  int checks;
  int failures;
  bit exp_done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Expected stream for a range: count = ((last-first) mod depth) + 1.
  task automatic push_range(input int first, input int last);
    int cnt;
    exp_t e;
    cnt = ((last - first) + DEPTH) % DEPTH + 1;
    for (int i = 0; i < cnt; i++) begin
      e.a = AW'((first + i) % DEPTH);
      e.d = (e.a == 0) ? '0 : ref_mem[e.a];
      e.l = (i == cnt - 1);
      sb.push_back(e);
    end
  endtask

  // Monitor: samples at negedge, away from the active edge.
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (exp_done) begin
        chk("done_pulse", {63'd0, o_done}, 64'd1);
        exp_done = 1'b0;
      end else if (o_done) begin
        chk("unexpected_done", {63'd0, o_done}, 64'd0);
      end
      if (dif.o_valid && dif.i_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_word", {26'd0, dif.o_addr, dif.o_data, dif.o_last}, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("word", {26'd0, dif.o_addr, dif.o_data, dif.o_last}, {26'd0, e.a, e.d, e.l});
          if (e.l) exp_done = 1'b1;
        end
      end
    end
  end

  task automatic wr_reg(input int a, input logic [DW-1:0] d);
    rf_we    = 1'b1;
    rf_waddr = AW'(a);
    rf_wdata = d;
    @(posedge i_clk); #1;
    rf_we = 1'b0;
    ref_mem[a] = d;
  endtask

  // Runs one dump; called at posedge+1 with the DUT idle, returns at posedge+1 idle.
  // rnd: random ready. stall_a: address to stall 5 cycles on (-1 none).
  // pulse_n: cycle to pulse a stray start (-1 none). wr_hit: write wr_d to
  // the first address at the edge where it is sampled by the regfile.
  task automatic run_dump(input int first, input int last, input bit rnd,
                          input int stall_a, input int pulse_n,
                          input bit wr_hit, input logic [DW-1:0] wr_d,
                          output int n);
    bit stalled;
    logic [63:0] snap;
    stalled = 1'b0;
    push_range(first, last);
    i_start = 1'b1;
    i_first = AW'(first);
    i_last  = AW'(last);
    dif.i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    chk("busy_after_start", {63'd0, o_busy}, 64'd1);
    chk("raddr_after_start", {59'd0, o_raddr}, {59'd0, AW'(first)});
    if (wr_hit) begin
      rf_we = 1'b1; rf_waddr = AW'(first); rf_wdata = wr_d;
    end
    n = 0;
    while (n < 2000) begin
      @(posedge i_clk); #1;
      n++;
      if (n == 1 && wr_hit) begin
        rf_we = 1'b0;
        ref_mem[first] = wr_d;
      end
      if (n == 1) chk("valid_low_e1", {63'd0, dif.o_valid}, 64'd0);
      if (n == 2) chk("valid_high_e2", {63'd0, dif.o_valid}, 64'd1);
      if (pulse_n >= 0 && n == pulse_n) begin
        i_start = 1'b1; i_first = AW'($urandom); i_last = AW'($urandom);
      end else begin
        i_start = 1'b0;
      end
      if (o_done) break;
      if (stall_a >= 0 && !stalled && dif.o_valid && dif.o_addr == AW'(stall_a)) begin
        dif.i_ready = 1'b0;
        snap = {21'd0, dif.o_valid, dif.o_data, dif.o_addr, o_raddr};
        repeat (5) begin
          @(posedge i_clk); #1;
          n++;
          chk("stall_hold", {21'd0, dif.o_valid, dif.o_data, dif.o_addr, o_raddr}, snap);
        end
        dif.i_ready = 1'b1;
        stalled = 1'b1;
      end else begin
        dif.i_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
    if (!o_done) chk("dump_timeout", 64'd0, 64'd1);
    i_start = 1'b0;
    dif.i_ready = 1'b1;
    @(posedge i_clk); #1;
  endtask

  initial begin
    int n;
    int cnt;
    int f, l;
    checks = 0; failures = 0; exp_done = 1'b0;
    i_rst_n = 1'b0; i_start = 1'b0; i_first = '0; i_last = '0;
    rf_we = 1'b0; rf_waddr = '0; rf_wdata = '0;
    dif.i_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      mem[k] = '0;
      ref_mem[k] = '0;
    end
    repeat (3) @(posedge i_clk);
    #1;
    chk("reset_state", {26'd0, dif.o_valid, dif.o_last, o_busy, o_done, o_raddr, dif.o_addr, dif.o_data},
        64'd0);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    for (int k = 1; k < DEPTH; k++) wr_reg(k, 32'hA500_0000 | k);

    // Full range, then a wrapped range, then a single word.
    run_dump(0, 31, 1'b0, -1, -1, 1'b0, '0, n);
    chk("full_dump_cycles", 64'(n), 64'd96);
    run_dump(30, 1, 1'b0, -1, -1, 1'b0, '0, n);
    chk("wrap_dump_cycles", 64'(n), 64'd12);
    run_dump(7, 7, 1'b0, -1, -1, 1'b0, '0, n);
    chk("single_dump_cycles", 64'(n), 64'd3);

    // Backpressure on address 3.
    run_dump(0, 5, 1'b0, 3, -1, 1'b0, '0, n);
    chk("stall_dump_cycles", 64'(n), 64'd23);

    // Stray start mid-dump is dropped.
    run_dump(10, 14, 1'b0, -1, 4, 1'b0, '0, n);
    repeat (8) @(posedge i_clk);
    #1;
    chk("stray_start_idle", {62'd0, o_busy, dif.o_valid}, 64'd0);
    chk("stray_start_no_extra", 64'(sb.size()), 64'd0);

    // Reset while a word waits in SEND.
    push_range(12, 12);
    i_start = 1'b1; i_first = AW'(12); i_last = AW'(12);
    dif.i_ready = 1'b0;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    cnt = 0;
    while (!dif.o_valid && cnt < 20) begin
      @(posedge i_clk); #1;
      cnt++;
    end
    chk("reached_send", {62'd0, dif.o_valid, dif.o_last}, 64'd3);
    #1;
    i_rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {61'd0, dif.o_valid, o_busy, dif.o_last}, 64'd0);
    sb.delete();
    exp_done = 1'b0;
    dif.i_ready = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    run_dump(16, 15, 1'b0, -1, -1, 1'b0, '0, n);
    chk("post_reset_full_cycles", 64'(n), 64'd96);

    // Write colliding with the read sample returns the old word; a re-dump sees the new one.
    run_dump(5, 5, 1'b0, -1, -1, 1'b1, 32'hDEAD_BEEF, n);
    run_dump(5, 5, 1'b0, -1, -1, 1'b0, '0, n);
    chk("redump_new_value", {32'd0, ref_mem[5]}, 64'hDEAD_BEEF);

    // Randomized contents, ranges and backpressure.
    for (int t = 0; t < 8; t++) begin
      repeat (3) wr_reg($urandom_range(0, 31), $urandom);
      f = $urandom_range(0, 31);
      l = $urandom_range(0, 31);
      run_dump(f, l, 1'b1, -1, -1, 1'b0, '0, n);
    end

    repeat (3) @(posedge i_clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
